// File: rtl/mac_mul_pipe.sv
// Two-stage unsigned slice multiplier: S1 registers four W x W partial products,
// S2 assembles them into a zero-extended result for single, dual or quad mode.
module mac_mul_pipe #(
  parameter int MAC_CONF_WIDTH = 3,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_MULT_WIDTH = 2*MAC_MIN_WIDTH,
  parameter int MAC_INT_WIDTH  = 5*MAC_MIN_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MAC_MIN_WIDTH-1:0]  A0,
  input  logic [MAC_MIN_WIDTH-1:0]  A1,
  input  logic [MAC_MIN_WIDTH-1:0]  A2,
  input  logic [MAC_MIN_WIDTH-1:0]  A3,
  input  logic [MAC_MIN_WIDTH-1:0]  B3,
  input  logic [MAC_CONF_WIDTH-1:0] cfg,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MAC_INT_WIDTH-1:0]  C,
  output logic                      cfg_err
);

  // Handshake: a beat moves on a rising edge only when valid & ready are both
  // high; both stages freeze while en is low, and in_ready is low in reset.
  typedef enum logic [1:0] {
    MODE_SINGLE  = 2'd0,
    MODE_DUAL    = 2'd1,
    MODE_QUAD    = 2'd2,
    MODE_ILLEGAL = 2'd3
  } mode_e;

  logic [3:0][MAC_MIN_WIDTH-1:0]  a_slice;
  logic                           s1_adv;
  logic                           s2_adv;

  logic                           s1_valid_q, s1_valid_d;
  mode_e                          s1_mode_q,  s1_mode_d;
  logic [3:0][MAC_MULT_WIDTH-1:0] s1_pp_q,    s1_pp_d;

  logic                           s2_valid_q, s2_valid_d;
  logic [MAC_INT_WIDTH-1:0]       s2_c_q,     s2_c_d;
  logic                           s2_err_q,   s2_err_d;

  logic [MAC_INT_WIDTH-1:0]       sum;
  logic                           err;
  logic                           unused_cfg_hi;

  assign a_slice       = {A3, A2, A1, A0};
  assign unused_cfg_hi = ^cfg[MAC_CONF_WIDTH-1:2];

  assign s2_adv   = en & (~s2_valid_q | out_ready);
  assign s1_adv   = en & (~s1_valid_q | s2_adv);
  assign in_ready = rst & s1_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_pp_d    = s1_pp_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      s1_mode_d  = mode_e'(cfg[1:0]);
      for (int i = 0; i < 4; i++) begin
        s1_pp_d[i] = MAC_MULT_WIDTH'(a_slice[i]) * MAC_MULT_WIDTH'(B3);
      end
    end
  end

  // Full-width adds so carries ripple across every slice boundary.
  always_comb begin
    sum = '0;
    err = 1'b0;
    case (s1_mode_q)
      MODE_SINGLE: sum = MAC_INT_WIDTH'(s1_pp_q[3]);
      MODE_DUAL:   sum = MAC_INT_WIDTH'(s1_pp_q[2])
                       + (MAC_INT_WIDTH'(s1_pp_q[3]) << MAC_MIN_WIDTH);
      MODE_QUAD:   sum = MAC_INT_WIDTH'(s1_pp_q[0])
                       + (MAC_INT_WIDTH'(s1_pp_q[1]) << MAC_MIN_WIDTH)
                       + (MAC_INT_WIDTH'(s1_pp_q[2]) << (2*MAC_MIN_WIDTH))
                       + (MAC_INT_WIDTH'(s1_pp_q[3]) << (3*MAC_MIN_WIDTH));
      default:     err = 1'b1;
    endcase
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_c_d     = s2_c_q;
    s2_err_d   = s2_err_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      s2_c_d     = sum;
      s2_err_d   = err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= MODE_SINGLE;
      s1_pp_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_c_q     <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_pp_q    <= s1_pp_d;
      s2_valid_q <= s2_valid_d;
      s2_c_q     <= s2_c_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign C         = s2_c_q;
  assign cfg_err   = s2_err_q;

endmodule

// File: tb/tb_mac_mul_pipe.sv
// Bench for mac_mul_pipe: directed scenarios plus random traffic, all results
// checked every cycle against an arithmetic model through an expected queue.
module tb_mac_mul_pipe;
  localparam int W  = 8;
  localparam int CW = 3;
  localparam int IW = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  A0 = '0, A1 = '0, A2 = '0, A3 = '0, B3 = '0;
  logic [CW-1:0] cfg = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] C;
  logic          cfg_err;

  int            total = 0;
  int            bad = 0;
  logic [IW:0]   exp_q[$];
  logic          hold = 1'b0;
  logic [IW:0]   hold_val = '0;
  logic          saw_bp = 1'b0;

  always #5 clk = ~clk;

  mac_mul_pipe dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .A0(A0), .A1(A1), .A2(A2), .A3(A3), .B3(B3), .cfg(cfg),
    .out_valid(out_valid), .out_ready(out_ready), .C(C), .cfg_err(cfg_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // {cfg_err, C} straight from the arithmetic definition of each mode.
  function automatic logic [IW:0] model(input logic [CW-1:0] c, input logic [W-1:0] a0,
                                        input logic [W-1:0] a1, input logic [W-1:0] a2,
                                        input logic [W-1:0] a3, input logic [W-1:0] b);
    logic [63:0] a;
    logic [63:0] p;
    a = '0;
    case (c[1:0])
      2'd0:    a = {56'd0, a3};
      2'd1:    a = {48'd0, a3, a2};
      2'd2:    a = {32'd0, a3, a2, a1, a0};
      default: return {1'b1, 40'd0};
    endcase
    p = a * {56'd0, b};
    return {1'b0, p[IW-1:0]};
  endfunction

  // Compare process: everything is sampled at the falling edge, where inputs
  // and outputs show exactly what the next rising edge will act on.
  always @(negedge clk) begin
    logic [IW:0] e;
    if (!rst) begin
      exp_q.delete();
      hold = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_c", 64'(C), 64'd0);
      chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    end else begin
      if (!en) chk("stall_in_ready", 64'(in_ready), 64'd0);
      if (hold) begin
        chk("hold_out_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'({cfg_err, C}), 64'(hold_val));
      end
      if (out_valid && out_ready && en) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_result: got C=%h err=%b want no result", C, cfg_err);
        end else begin
          e = exp_q.pop_front();
          chk("result", 64'({cfg_err, C}), 64'(e));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(cfg, A0, A1, A2, A3, B3));
      if (in_valid && !in_ready && en) saw_bp = 1'b1;
      hold     = out_valid && !(out_ready && en);
      hold_val = {cfg_err, C};
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present a beat and hold it until accepted; returns cycles spent waiting.
  task automatic send(input logic [CW-1:0] c, input logic [W-1:0] a0, input logic [W-1:0] a1,
                      input logic [W-1:0] a2, input logic [W-1:0] a3, input logic [W-1:0] b,
                      output int waits);
    waits = 0;
    cfg = c; A0 = a0; A1 = a1; A2 = a2; A3 = a3; B3 = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [IW-1:0] c, input logic e,
                            output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_ready && en) && n < 100);
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no result want one within 100 cycles", name);
    end else begin
      chk(name, 64'(C), 64'(c));
      chk({name, "_err"}, 64'(cfg_err), 64'(e));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w1, w2, n1, n2, cnt;

    chk("pin_single", 64'(model(3'd0, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF)), 64'h0_0000_FE01);
    chk("pin_dual", 64'(model(3'd1, 8'h00, 8'h00, 8'h34, 8'h12, 8'h10)), 64'h0_0001_2340);
    chk("pin_quad", 64'(model(3'd2, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF)), 64'h0_FEFF_FFFF_01);
    chk("pin_illegal", 64'(model(3'd3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05)), 64'h100_0000_0000);
    chk("pin_cfg2_ignored", 64'(model(3'd4, 8'h09, 8'h09, 8'h09, 8'h02, 8'h03)), 64'h6);

    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    en = 1'b1;
    out_ready = 1'b1;

    // Single mode and pipeline timing: beat taken on edge 1 shows after edge 2.
    sync();
    send(3'd0, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, w1);
    chk("lat_after_accept_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_second_edge_valid", 64'(out_valid), 64'd1);
    chk("single_c", 64'(C), 64'hFE01);
    chk("single_err", 64'(cfg_err), 64'd0);

    // Dual then quad back-to-back.
    sync();
    fork
      begin
        send(3'd1, 8'h00, 8'h00, 8'h34, 8'h12, 8'h10, w1);
        send(3'd2, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, w2);
        chk("b2b_accept_wait", 64'(w2), 64'd0);
      end
      begin
        expect_out("dual_c", 40'h00_0001_2340, 1'b0, n1);
        expect_out("quad_c", 40'hFE_FFFF_FF01, 1'b0, n2);
        chk("b2b_result_gap", 64'(n2), 64'd1);
      end
    join

    // Illegal mode followed by a cfg change.
    sync();
    fork
      begin
        send(3'd3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, w1);
        send(3'd0, 8'h00, 8'h00, 8'h00, 8'h02, 8'h03, w2);
      end
      begin
        expect_out("illegal_c", 40'd0, 1'b1, n1);
        expect_out("after_illegal_c", 40'd6, 1'b0, n2);
      end
    join

    // Backpressure: six quad beats with out_ready low for three cycles.
    sync();
    saw_bp = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(3'd2, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), w1);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 20) begin
      @(posedge clk);
      cnt++;
    end
    chk("bp_in_ready_dropped", 64'(saw_bp), 64'd1);
    chk("bp_all_drained", 64'(exp_q.size()), 64'd0);

    // Stall with two beats in flight, then asynchronous reset mid-stream.
    sync();
    send(3'd0, 8'h00, 8'h00, 8'h00, 8'h05, 8'h07, w1);
    send(3'd0, 8'h00, 8'h00, 8'h00, 8'h09, 8'h09, w2);
    en = 1'b0;
    cfg = 3'd0; A3 = 8'h04; B3 = 8'h04;
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("freeze_in_ready", 64'(in_ready), 64'd0);
      chk("freeze_out_valid", 64'(out_valid), 64'd1);
      chk("freeze_c", 64'(C), 64'd35);
      @(posedge clk);
    end
    #1 en = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd0);
    chk("async_rst_c", 64'(C), 64'd0);
    chk("async_rst_err", 64'(cfg_err), 64'd0);
    cfg = 3'd1; A2 = 8'h03; A3 = 8'h00; B3 = 8'h05;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("release_no_stale", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("release_first_valid", 64'(out_valid), 64'd1);
    chk("release_first_c", 64'(C), 64'd15);

    // Random traffic with random stalls, backpressure and modes.
    sync();
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 7) != 0);
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cfg = 3'($urandom_range(0, 7));
      A0 = 8'($urandom); A1 = 8'($urandom); A2 = 8'($urandom); A3 = 8'($urandom);
      B3 = 8'($urandom);
      @(posedge clk);
      #1;
    end
    en = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 50) begin
      @(posedge clk);
      cnt++;
    end
    chk("final_drain", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
